decode_stage: RTL and testbench

Registered, parametrised instruction-decode stage with a valid/ready handshake and an internal return-address stack (RAS). It accepts one instruction word per cycle from fetch and splits it into operand, destination and source-select fields. It resolves jump, call and return conditions against the zero flag and presents a single redirect target to the PC logic. It sits between instruction fetch and the ALU/register-file stage.

---
 rtl/decode_stage_if.sv | 59 +++++
 rtl/decode_stage.sv | 233 +++++++++++++++++++++++
 tb/tb_decode_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the fetch-side handshake, the decoded-output
// handshake and the return-address-stack status of decode_stage.
//   master : the environment (fetch, PC logic, ALU stage). It drives
//            in_valid/instr/pc/zero_flag/flush/out_ready.
//   slave  : decode_stage itself. It drives in_ready and every decoded
//            output.
// Widths follow the same parameters as decode_stage and must be overridden
// to identical values on both.
interface decode_stage_if #(
  parameter int PC_WIDTH          = 5,
  parameter int OPCODE_WIDTH      = 6,
  parameter int VALUE_WIDTH       = 8,
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int RAS_DEPTH         = 4
);
  localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

  logic                         in_valid;
  logic                         in_ready;
  logic [INSTRUCTION_WIDTH-1:0] instr;
  logic [PC_WIDTH-1:0]          pc;
  logic                         zero_flag;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [OPCODE_WIDTH-1:0]      op_code;
  logic [VALUE_WIDTH-1:0]       source1;
  logic [VALUE_WIDTH-1:0]       source2;
  logic [VALUE_WIDTH-1:0]       destination;
  logic [1:0]                   source1_choice;
  logic [1:0]                   source2_choice;
  logic [1:0]                   destination_choice;
  logic                         jmp;
  logic                         cal;
  logic                         ret;
  logic                         push;
  logic                         pop;
  logic                         redirect;
  logic [PC_WIDTH-1:0]          redirect_target;
  logic [CNT_W-1:0]             ras_count;
  logic                         ras_overflow;
  logic                         ras_underflow;

  modport master (
    output in_valid, instr, pc, zero_flag, flush, out_ready,
    input  in_ready, out_valid, op_code, source1, source2, destination,
           source1_choice, source2_choice, destination_choice,
           jmp, cal, ret, push, pop, redirect, redirect_target,
           ras_count, ras_overflow, ras_underflow
  );

  modport slave (
    input  in_valid, instr, pc, zero_flag, flush, out_ready,
    output in_ready, out_valid, op_code, source1, source2, destination,
           source1_choice, source2_choice, destination_choice,
           jmp, cal, ret, push, pop, redirect, redirect_target,
           ras_count, ras_overflow, ras_underflow
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage with valid/ready
// handshake and a circular return-address stack (RAS).
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   bus    - decode_stage_if.slave: in_valid/in_ready/instr/pc/zero_flag/
//            flush in, out_valid/out_ready plus decoded fields, resolved
//            control (jmp/cal/ret/push/pop), redirect/redirect_target and
//            RAS status (ras_count, sticky ras_overflow/ras_underflow).
// Build option: DECODE_STAGE_RAS_EN enables the internal stack. Without it
// push/pop still pulse for an external stack, a taken return redirects to 0
// and the RAS status outputs are tied to 0.
module decode_stage #(
  parameter int PC_WIDTH          = 5,
  parameter int OPCODE_WIDTH      = 6,
  parameter int VALUE_WIDTH       = 8,
  parameter int INSTRUCTION_WIDTH = 40,
  parameter int RAS_DEPTH         = 4
) (
  input logic          clk,
  input logic          rst_n,
  decode_stage_if.slave bus
);
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [OPCODE_WIDTH-1:0] OP_JMP     = OPCODE_WIDTH'('h20);
  localparam logic [OPCODE_WIDTH-1:0] OP_IF0JUMP = OPCODE_WIDTH'('h21);
  localparam logic [OPCODE_WIDTH-1:0] OP_IF1JUMP = OPCODE_WIDTH'('h22);
  localparam logic [OPCODE_WIDTH-1:0] OP_CALL    = OPCODE_WIDTH'('h23);
  localparam logic [OPCODE_WIDTH-1:0] OP_CAL0    = OPCODE_WIDTH'('h24);
  localparam logic [OPCODE_WIDTH-1:0] OP_CAL1    = OPCODE_WIDTH'('h25);
  localparam logic [OPCODE_WIDTH-1:0] OP_RET     = OPCODE_WIDTH'('h26);
  localparam logic [OPCODE_WIDTH-1:0] OP_RET0    = OPCODE_WIDTH'('h27);
  localparam logic [OPCODE_WIDTH-1:0] OP_RET1    = OPCODE_WIDTH'('h28);

  // Field extraction
  logic [OPCODE_WIDTH-1:0] f_op;
  logic [VALUE_WIDTH-1:0]  f_src1, f_src2, f_dst;
  logic [1:0]              f_c1, f_c2, f_cd;
  logic                    unused_instr_bits;

  assign f_op   = bus.instr[32 +: OPCODE_WIDTH];
  assign f_src1 = bus.instr[24 +: VALUE_WIDTH];
  assign f_src2 = bus.instr[16 +: VALUE_WIDTH];
  assign f_dst  = bus.instr[8 +: VALUE_WIDTH];
  assign f_c1   = bus.instr[5:4];
  assign f_c2   = bus.instr[3:2];
  assign f_cd   = bus.instr[1:0];
  assign unused_instr_bits = ^{bus.instr[INSTRUCTION_WIDTH-1:32+OPCODE_WIDTH],
                               bus.instr[7:6]};

  // Handshake
  logic out_valid_q;
  logic in_ready_int;
  logic accept;

  assign in_ready_int = ~bus.flush & (~out_valid_q | bus.out_ready);
  assign accept       = bus.in_valid & in_ready_int;
  assign bus.in_ready = in_ready_int;

  // Control resolution
  logic                c_jmp, c_cal, c_ret, c_push, c_pop;
  logic [PC_WIDTH-1:0] c_target;
  logic [PC_WIDTH-1:0] ras_top;

  always_comb begin
    c_jmp  = 1'b0;
    c_cal  = 1'b0;
    c_ret  = 1'b0;
    c_push = 1'b0;
    c_pop  = 1'b0;
    case (f_op)
      OP_JMP:     c_jmp = 1'b1;
      OP_IF0JUMP: c_jmp = bus.zero_flag;
      OP_IF1JUMP: c_jmp = ~bus.zero_flag;
      OP_CALL: begin
        c_jmp  = 1'b1;
        c_cal  = 1'b1;
        c_push = 1'b1;
      end
      OP_CAL0: begin
        c_jmp  = bus.zero_flag;
        c_cal  = bus.zero_flag;
        c_push = bus.zero_flag;
      end
      OP_CAL1: begin
        c_jmp  = ~bus.zero_flag;
        c_cal  = ~bus.zero_flag;
        c_push = ~bus.zero_flag;
      end
      OP_RET: begin
        c_ret = 1'b1;
        c_pop = 1'b1;
      end
      OP_RET0: begin
        c_ret = bus.zero_flag;
        c_pop = bus.zero_flag;
      end
      OP_RET1: begin
        c_ret = ~bus.zero_flag;
        c_pop = ~bus.zero_flag;
      end
      default: ;
    endcase

    c_target = '0;
    if (c_ret) begin
      c_target = ras_top;
    end else if (c_jmp) begin
      c_target = f_src1[PC_WIDTH-1:0];
    end
  end

`ifdef DECODE_STAGE_RAS_EN
  // Return-address stack. ras_sp is the next write slot; being a power-of-two
  // wide pointer it wraps on its own, so a push when full simply overwrites
  // the oldest entry while ras_cnt saturates at RAS_DEPTH.
  logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]    ras_sp;
  logic [CNT_W-1:0]    ras_cnt;
  logic                ras_ovf, ras_udf;

  assign ras_top = (ras_cnt == '0) ? '0 : ras_mem[ras_sp - PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_sp  <= '0;
      ras_cnt <= '0;
      ras_ovf <= 1'b0;
      ras_udf <= 1'b0;
    end else if (accept) begin
      if (c_push) begin
        ras_sp <= ras_sp + PTR_W'(1);
        if (ras_cnt == CNT_W'(RAS_DEPTH)) begin
          ras_ovf <= 1'b1;
        end else begin
          ras_cnt <= ras_cnt + CNT_W'(1);
        end
      end else if (c_pop) begin
        if (ras_cnt == '0) begin
          ras_udf <= 1'b1;
        end else begin
          ras_sp  <= ras_sp - PTR_W'(1);
          ras_cnt <= ras_cnt - CNT_W'(1);
        end
      end
    end
  end

  // Entries need no reset: they are only read while ras_cnt is non-zero.
  always_ff @(posedge clk) begin
    if (rst_n && accept && c_push) begin
      ras_mem[ras_sp] <= bus.pc + PC_WIDTH'(1);
    end
  end

  assign bus.ras_count     = ras_cnt;
  assign bus.ras_overflow  = ras_ovf;
  assign bus.ras_underflow = ras_udf;
`else
  logic unused_pc;

  assign ras_top           = '0;
  assign unused_pc         = ^bus.pc;
  assign bus.ras_count     = '0;
  assign bus.ras_overflow  = 1'b0;
  assign bus.ras_underflow = 1'b0;
`endif

  // Output register
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [VALUE_WIDTH-1:0]  src1_q, src2_q, dst_q;
  logic [1:0]              c1_q, c2_q, cd_q;
  logic                    jmp_q, cal_q, ret_q, push_q, pop_q, redirect_q;
  logic [PC_WIDTH-1:0]     target_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      src1_q      <= '0;
      src2_q      <= '0;
      dst_q       <= '0;
      c1_q        <= '0;
      c2_q        <= '0;
      cd_q        <= '0;
      jmp_q       <= 1'b0;
      cal_q       <= 1'b0;
      ret_q       <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      redirect_q  <= 1'b0;
      target_q    <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      op_q        <= f_op;
      src1_q      <= f_src1;
      src2_q      <= f_src2;
      dst_q       <= f_dst;
      c1_q        <= f_c1;
      c2_q        <= f_c2;
      cd_q        <= f_cd;
      jmp_q       <= c_jmp;
      cal_q       <= c_cal;
      ret_q       <= c_ret;
      push_q      <= c_push;
      pop_q       <= c_pop;
      redirect_q  <= c_jmp | c_ret;
      target_q    <= c_target;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid          = out_valid_q;
  assign bus.op_code            = op_q;
  assign bus.source1            = src1_q;
  assign bus.source2            = src2_q;
  assign bus.destination        = dst_q;
  assign bus.source1_choice     = c1_q;
  assign bus.source2_choice     = c2_q;
  assign bus.destination_choice = cd_q;
  assign bus.jmp                = jmp_q;
  assign bus.cal                = cal_q;
  assign bus.ret                = ret_q;
  assign bus.push               = push_q;
  assign bus.pop                = pop_q;
  assign bus.redirect           = redirect_q;
  assign bus.redirect_target    = target_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: randomized and directed stimulus for decode_stage with a
// queue-based reference model checked every cycle, plus literal checks that
// pin the model on the documented scenarios.
module tb_decode_stage;
  localparam int PW = 5;
  localparam int OW = 6;
  localparam int VW = 8;
  localparam int IW = 40;
  localparam int RD = 4;
`ifdef DECODE_STAGE_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  decode_stage_if #(.PC_WIDTH(PW), .OPCODE_WIDTH(OW), .VALUE_WIDTH(VW),
                    .INSTRUCTION_WIDTH(IW), .RAS_DEPTH(RD)) bus ();

  decode_stage #(.PC_WIDTH(PW), .OPCODE_WIDTH(OW), .VALUE_WIDTH(VW),
                 .INSTRUCTION_WIDTH(IW), .RAS_DEPTH(RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit              m_live = 1'b0;
  bit              m_valid;
  logic [IW-1:0]   m_instr;
  logic [4:0]      m_ctl;     // {push,pop,jmp,cal,ret}
  logic [PW-1:0]   m_tgt;
  logic [PW-1:0]   stk[$];    // back = top of stack
  bit              m_ovf, m_udf;

  task automatic predict(input logic [IW-1:0] ins, input logic [PW-1:0] p, input logic zf);
    int  op, grp, sfx;
    bit  taken;
    op      = int'(ins[37:32]);
    m_instr = ins;
    m_ctl   = 5'b0;
    m_tgt   = '0;
    if (op >= 'h20 && op <= 'h28) begin
      grp   = (op - 'h20) / 3;
      sfx   = (op - 'h20) % 3;
      taken = (sfx == 0) || (sfx == 1 && zf) || (sfx == 2 && !zf);
      if (taken) begin
        case (grp)
          0: begin
            m_ctl = 5'b00100;
            m_tgt = ins[24 +: PW];
          end
          1: begin
            m_ctl = 5'b10110;
            m_tgt = ins[24 +: PW];
            if (stk.size() == RD) begin
              void'(stk.pop_front());
              m_ovf = 1'b1;
            end
            stk.push_back(PW'(p + 1));
          end
          default: begin
            m_ctl = 5'b01001;
            if (stk.size() == 0) begin
              m_udf = 1'b1;
            end else begin
              m_tgt = stk.pop_back();
            end
            if (!RAS_EN) m_tgt = '0;
          end
        endcase
      end
    end
  endtask

  // Compare against the model, then advance it with the inputs that the
  // coming rising edge will sample (inputs only change just after an edge).
  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", 32'(bus.in_ready), 32'(!bus.flush && (!m_valid || bus.out_ready)));
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("op_code", 32'(bus.op_code), 32'(m_instr[37:32]));
        chk("source1", 32'(bus.source1), 32'(m_instr[31:24]));
        chk("source2", 32'(bus.source2), 32'(m_instr[23:16]));
        chk("destination", 32'(bus.destination), 32'(m_instr[15:8]));
        chk("choices", 32'({bus.source1_choice, bus.source2_choice, bus.destination_choice}),
            32'(m_instr[5:0]));
        chk("control", 32'({bus.push, bus.pop, bus.jmp, bus.cal, bus.ret}), 32'(m_ctl));
        chk("redirect", 32'(bus.redirect), 32'(m_ctl[2] | m_ctl[0]));
        chk("redirect_target", 32'(bus.redirect_target), 32'(m_tgt));
      end
      chk("ras_count", 32'(bus.ras_count), RAS_EN ? 32'(stk.size()) : 32'd0);
      chk("ras_overflow", 32'(bus.ras_overflow), RAS_EN ? 32'(m_ovf) : 32'd0);
      chk("ras_underflow", 32'(bus.ras_underflow), RAS_EN ? 32'(m_udf) : 32'd0);
    end
    if (!rst_n) begin
      m_live  = 1'b1;
      m_valid = 1'b0;
      stk.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else if (m_live) begin
      if (bus.flush) begin
        m_valid = 1'b0;
      end else if (bus.in_valid && (!m_valid || bus.out_ready)) begin
        predict(bus.instr, bus.pc, bus.zero_flag);
        m_valid = 1'b1;
      end else if (bus.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [IW-1:0] mk(input logic [5:0] op, input logic [7:0] s1);
    mk = {2'b00, op, s1, 8'hA5, 8'h3C, 2'b00, 6'b100111};
  endfunction

  task automatic drive(input logic v, input logic [IW-1:0] ins, input logic [PW-1:0] p,
                       input logic z, input logic fl, input logic ordy);
    bus.in_valid  = v;
    bus.instr     = ins;
    bus.pc        = p;
    bus.zero_flag = z;
    bus.flush     = fl;
    bus.out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [IW-1:0] ins;
    logic [5:0]    op;
    rst_n = 1'b0;
    idle();
    idle();
    // reset state
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_target", 32'(bus.redirect_target), 32'd0);
    chk("rst_ras_count", 32'(bus.ras_count), 32'd0);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // JMP 0x13
    drive(1'b1, mk(6'h20, 8'h13), 5'd1, 1'b0, 1'b0, 1'b1);
    chk("jmp_valid", 32'(bus.out_valid), 32'd1);
    chk("jmp_ctl", 32'({bus.push, bus.pop, bus.jmp, bus.cal, bus.ret}), 32'b00100);
    chk("jmp_target", 32'(bus.redirect_target), 32'h13);
    chk("jmp_source2", 32'(bus.source2), 32'hA5);

    // IF0JUMP not taken / taken
    drive(1'b1, mk(6'h21, 8'h0B), 5'd2, 1'b0, 1'b0, 1'b1);
    chk("if0_nt_ctl", 32'({bus.push, bus.pop, bus.jmp, bus.cal, bus.ret, bus.redirect}), 32'd0);
    drive(1'b1, mk(6'h21, 8'h0B), 5'd3, 1'b1, 1'b0, 1'b1);
    chk("if0_t_jmp", 32'(bus.jmp), 32'd1);
    chk("if0_t_target", 32'(bus.redirect_target), 32'h0B);

    // CALL at pc 5 then RET
    drive(1'b1, mk(6'h23, 8'h10), 5'd5, 1'b0, 1'b0, 1'b1);
    chk("call_ctl", 32'({bus.push, bus.pop, bus.jmp, bus.cal, bus.ret}), 32'b10110);
    chk("call_target", 32'(bus.redirect_target), 32'h10);
    chk("call_count", 32'(bus.ras_count), RAS_EN ? 32'd1 : 32'd0);
    drive(1'b1, mk(6'h26, 8'h00), 5'd16, 1'b0, 1'b0, 1'b1);
    chk("ret_ctl", 32'({bus.push, bus.pop, bus.jmp, bus.cal, bus.ret}), 32'b01001);
    chk("ret_target", 32'(bus.redirect_target), RAS_EN ? 32'h06 : 32'h00);
    chk("ret_count", 32'(bus.ras_count), 32'd0);

    // overflow then underflow
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b1, mk(6'h23, 8'h1F), PW'(i), 1'b0, 1'b0, 1'b1);
    chk("ovf_flag", 32'(bus.ras_overflow), RAS_EN ? 32'd1 : 32'd0);
    chk("ovf_count", 32'(bus.ras_count), RAS_EN ? 32'd4 : 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, mk(6'h26, 8'h00), 5'd0, 1'b0, 1'b0, 1'b1);
      chk("ovf_ret_target", 32'(bus.redirect_target), RAS_EN ? 32'(5 - i) : 32'd0);
    end
    chk("udf_flag_before", 32'(bus.ras_underflow), 32'd0);
    drive(1'b1, mk(6'h26, 8'h00), 5'd0, 1'b0, 1'b0, 1'b1);
    chk("udf_target", 32'(bus.redirect_target), 32'd0);
    chk("udf_flag", 32'(bus.ras_underflow), RAS_EN ? 32'd1 : 32'd0);
    chk("udf_count", 32'(bus.ras_count), 32'd0);

    // stall for three cycles, then exactly one accept
    drive(1'b1, mk(6'h20, 8'h07), 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, mk(6'h20, 8'h09), 5'd0, 1'b0, 1'b0, 1'b0);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_target", 32'(bus.redirect_target), 32'h07);
    end
    drive(1'b1, mk(6'h20, 8'h09), 5'd0, 1'b0, 1'b0, 1'b1);
    chk("release_target", 32'(bus.redirect_target), 32'h09);
    idle();
    chk("release_drain", 32'(bus.out_valid), 32'd0);

    // flush beats a simultaneous CALL
    drive(1'b1, mk(6'h23, 8'h02), 5'd9, 1'b0, 1'b0, 1'b1);
    drive(1'b1, mk(6'h23, 8'h02), 5'd12, 1'b0, 1'b1, 1'b1);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_count", 32'(bus.ras_count), RAS_EN ? 32'd1 : 32'd0);

    // mid-stream reset with three live entries
    drive(1'b1, mk(6'h23, 8'h02), 5'd13, 1'b0, 1'b0, 1'b1);
    drive(1'b1, mk(6'h23, 8'h02), 5'd14, 1'b0, 1'b0, 1'b1);
    chk("mid_count", 32'(bus.ras_count), RAS_EN ? 32'd3 : 32'd0);
    rst_n = 1'b0;
    drive(1'b1, mk(6'h23, 8'h02), 5'd15, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_outs", 32'({bus.op_code, bus.source1, bus.push, bus.jmp, bus.cal, bus.redirect,
                             bus.redirect_target}), 32'd0);
    chk("mid_rst_count", 32'(bus.ras_count), 32'd0);
    rst_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) != 0) op = 6'(32'h20 + $urandom_range(0, 8));
      else                           op = 6'($urandom);
      ins = {2'($urandom), op, 32'($urandom)};
      rst_n = ($urandom_range(0, 299) != 0);
      drive(1'($urandom_range(0, 3) != 0), ins, PW'($urandom), 1'($urandom),
            1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 3) != 0));
    end
    rst_n = 1'b1;
    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
